// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad front end: button codes, scanner states
// and the reserved-code test used when a debounced press is accepted.
package keypad_pkg;

    localparam logic [4:0] KEY_NONE     = 5'b11111;
    localparam logic [4:0] KEY_0        = 5'd0;
    localparam logic [4:0] KEY_1        = 5'd1;
    localparam logic [4:0] KEY_2        = 5'd2;
    localparam logic [4:0] KEY_3        = 5'd3;
    localparam logic [4:0] KEY_4        = 5'd4;
    localparam logic [4:0] KEY_5        = 5'd5;
    localparam logic [4:0] KEY_6        = 5'd6;
    localparam logic [4:0] KEY_7        = 5'd7;
    localparam logic [4:0] KEY_8        = 5'd8;
    localparam logic [4:0] KEY_9        = 5'd9;
    localparam logic [4:0] KEY_ADD      = 5'd10;
    localparam logic [4:0] KEY_SUB      = 5'd11;
    localparam logic [4:0] KEY_MUL      = 5'd12;
    localparam logic [4:0] KEY_DIV      = 5'd13;
    localparam logic [4:0] KEY_NEG      = 5'd14;
    localparam logic [4:0] KEY_EQ       = 5'd15;
    localparam logic [4:0] KEY_CLR      = 5'd16;
    localparam logic [4:0] KEY_RSVD_MIN = 5'd17;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_e;

    function automatic logic is_reserved(input logic [4:0] code);
        return code >= KEY_RSVD_MIN;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the asynchronous, active-low row lines.
// Resets to all ones so an idle (pulled-up) keypad is seen during reset.
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_n,
    output logic [WIDTH-1:0] q_n
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_n;
            sync_q <= meta_q;
        end
    end

    assign q_n = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x5 matrix keypad scanner: walks the columns, debounces a single-row hit,
// emits one valid_press pulse per accepted press and tracks the release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 5,
    parameter int SCAN_TICKS      = 1000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            enable,
    input  logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col_n,
    output logic [4:0]      button,
    output logic            valid_press,
    output logic            key_down,
    output state_e          dbg_state
);

    localparam int CNT_MAX = (SCAN_TICKS > DEBOUNCE_CYCLES) ? SCAN_TICKS : DEBOUNCE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0]    SCAN_LAST = CW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0]    DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       cand_q, cand_d;
    logic [ROW_W-1:0] cand_row_q, cand_row_d;
    logic [4:0]       button_q, button_d;
    logic             key_down_q, key_down_d;
    logic             valid_press_q, valid_press_d;
    logic [COLS-1:0]  col_n_q, col_n_d;

    logic [ROWS-1:0]  rs;
    logic [ROWS-1:0]  low_rows;
    logic             hit;
    logic [ROW_W-1:0] hit_row;
    logic [4:0]       hit_code;
    logic [CW-1:0]    cnt_inc;
    logic [COL_W-1:0] col_next;

    key_sync #(.WIDTH(ROWS)) u_sync (
        .clock  (clock),
        .resetn (resetn),
        .d_n    (row_n),
        .q_n    (rs)
    );

    // A hit is exactly one low row; none or several (ghosting) means no key.
    always_comb begin
        low_rows = ~rs;
        hit      = (low_rows != '0) && ((low_rows & (low_rows - ROWS'(1))) == '0);
        hit_row  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (low_rows[r]) hit_row = ROW_W'(r);
        end
        hit_code = 5'(int'(hit_row) * COLS + int'(col_q));
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        col_next = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        cnt_d         = cnt_q;
        cand_d        = cand_q;
        cand_row_d    = cand_row_q;
        button_d      = button_q;
        key_down_d    = key_down_q;
        valid_press_d = 1'b0;
        col_n_d       = enable ? ~(COLS'(1) << col_q) : '1;

        if (!enable) begin
            state_d    = SCAN;
            col_d      = '0;
            cnt_d      = '0;
            button_d   = KEY_NONE;
            key_down_d = 1'b0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_d = '0;
                        if (hit) begin
                            cand_d     = hit_code;
                            cand_row_d = hit_row;
                            state_d    = DEBOUNCE;
                        end else begin
                            col_d = col_next;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                DEBOUNCE: begin
                    if (!(hit && hit_row == cand_row_q)) begin
                        state_d = SCAN;
                        col_d   = col_next;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        // Reserved codes are swallowed but still need a release.
                        if (!is_reserved(cand_q)) begin
                            button_d      = cand_q;
                            key_down_d    = 1'b1;
                            valid_press_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (rs == '1) begin
                        cnt_d   = '0;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (rs != '1) begin
                        cnt_d = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d    = SCAN;
                        col_d      = '0;
                        cnt_d      = '0;
                        button_d   = KEY_NONE;
                        key_down_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= SCAN;
            col_q         <= '0;
            cnt_q         <= '0;
            cand_q        <= KEY_NONE;
            cand_row_q    <= '0;
            button_q      <= KEY_NONE;
            key_down_q    <= 1'b0;
            valid_press_q <= 1'b0;
            col_n_q       <= '1;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            cand_row_q    <= cand_row_d;
            button_q      <= button_d;
            key_down_q    <= key_down_d;
            valid_press_q <= valid_press_d;
            col_n_q       <= col_n_d;
        end
    end

    assign col_n       = col_n_q;
    assign button      = button_q;
    assign valid_press = valid_press_q;
    assign key_down    = key_down_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows, expected
// button codes are queued at stimulus time and popped on each valid_press.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int ROWS     = 4;
    localparam int COLS     = 5;
    localparam int SCAN_T   = 4;
    localparam int DEB      = 8;
    // Release is seen after two synchroniser stages, one cycle to leave the
    // held state, then DEB stable cycles.
    localparam int REL_LAT  = 2 + 1 + DEB;

    logic            clock;
    logic            resetn;
    logic            enable;
    logic [ROWS-1:0] row_n;
    logic [COLS-1:0] col_n;
    logic [4:0]      button;
    logic            valid_press;
    logic            key_down;
    state_e          dbg_state;

    logic [ROWS-1:0][COLS-1:0] held;
    logic [4:0]                exp_q[$];
    int                        vectors;
    int                        miscompares;
    int                        pulse_cnt;

    keypad_scanner #(
        .ROWS            (ROWS),
        .COLS            (COLS),
        .SCAN_TICKS      (SCAN_T),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .enable      (enable),
        .row_n       (row_n),
        .col_n       (col_n),
        .button      (button),
        .valid_press (valid_press),
        .key_down    (key_down),
        .dbg_state   (dbg_state)
    );

    // Clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Keypad model: row r is pulled low when column c is driven and key (r,c) is held.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_n[r] = 1'b1;
            for (int c = 0; c < COLS; c++) begin
                if (held[r][c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endfunction

    function automatic logic [4:0] key_code(input int r, input int c);
        return 5'(r * COLS + c);
    endfunction

    // Scoreboard monitor
    always @(negedge clock) begin
        if (resetn && valid_press) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(button), 32'(KEY_NONE));
                if (button == KEY_NONE) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse: got pulse required none");
                end
            end else begin
                check("pulse_button", 32'(button), 32'(exp_q.pop_front()));
                check("pulse_key_down", 32'(key_down), 32'd1);
            end
        end
    end

    // Driver tasks
    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_pulse(input int target, input int budget, input string name);
        int i;
        i = 0;
        while (pulse_cnt < target && i < budget) begin
            @(negedge clock);
            i++;
        end
        check(name, 32'(pulse_cnt), 32'(target));
    endtask

    task automatic press(input int r, input int c);
        held[r][c] = 1'b1;
        if (!is_reserved(key_code(r, c))) exp_q.push_back(key_code(r, c));
    endtask

    initial begin
        int base;
        logic [COLS-1:0] exp_col;
        logic [COLS-1:0] one;

        vectors     = 0;
        miscompares = 0;
        pulse_cnt   = 0;
        held        = '0;
        enable      = 1'b1;
        resetn      = 1'b1;
        one         = COLS'(1);

        // 1. reset values and column walk
        #1 resetn = 1'b0;
        #1;
        check("rst_col_n", 32'(col_n), 32'h1f);
        check("rst_button", 32'(button), 32'(KEY_NONE));
        check("rst_valid", 32'(valid_press), 32'd0);
        check("rst_key_down", 32'(key_down), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(SCAN));
        cycles(2);
        resetn = 1'b1;
        for (int k = 1; k <= 2 * COLS * SCAN_T + 4; k++) begin
            @(negedge clock);
            exp_col = ~(one << (((k - 1) / SCAN_T) % COLS));
            check("col_walk", 32'(col_n), 32'(exp_col));
        end

        // 2. key (1,2) held 60 cycles, then released
        base = pulse_cnt;
        press(1, 2);
        cycles(60);
        check("t2_one_pulse", 32'(pulse_cnt - base), 32'd1);
        check("t2_button_hold", 32'(button), 32'd7);
        check("t2_key_down_hold", 32'(key_down), 32'd1);
        held[1][2] = 1'b0;
        cycles(REL_LAT - 1);
        check("t2_still_down", 32'(key_down), 32'd1);
        check("t2_still_button", 32'(button), 32'd7);
        cycles(1);
        check("t2_released_kd", 32'(key_down), 32'd0);
        check("t2_released_btn", 32'(button), 32'(KEY_NONE));
        cycles(10);

        // 3. bouncing key (0,0), then stable
        base = pulse_cnt;
        for (int i = 0; i < 12; i++) begin
            held[0][0] = 1'b1;
            cycles(5);
            held[0][0] = 1'b0;
            cycles(2);
        end
        check("t3_no_bounce_pulse", 32'(pulse_cnt - base), 32'd0);
        press(0, 0);
        wait_pulse(base + 1, 80, "t3_stable_pulse");
        cycles(5);
        held[0][0] = 1'b0;
        cycles(20);

        // 4. two keys in one column, then one released
        base = pulse_cnt;
        held[0][3] = 1'b1;
        held[2][3] = 1'b1;
        cycles(60);
        check("t4_ghost_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("t4_ghost_button", 32'(button), 32'(KEY_NONE));
        held[0][3] = 1'b0;
        exp_q.push_back(key_code(2, 3));
        wait_pulse(base + 1, 80, "t4_pulse");
        cycles(5);
        held[2][3] = 1'b0;
        cycles(20);

        // 5. clear key, enable dropped for one cycle after the pulse
        base = pulse_cnt;
        press(3, 1);
        wait_pulse(base + 1, 80, "t5_first_pulse");
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        check("t5_off_button", 32'(button), 32'(KEY_NONE));
        check("t5_off_col_n", 32'(col_n), 32'h1f);
        check("t5_off_key_down", 32'(key_down), 32'd0);
        enable = 1'b1;
        exp_q.push_back(key_code(3, 1));
        wait_pulse(base + 2, 80, "t5_second_pulse");
        cycles(5);
        held[3][1] = 1'b0;
        cycles(20);

        // 6. reserved key, a second key ignored until its release
        base = pulse_cnt;
        press(3, 3);
        cycles(40);
        check("t6_rsvd_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("t6_rsvd_button", 32'(button), 32'(KEY_NONE));
        check("t6_rsvd_state", 32'(dbg_state), 32'(PRESSED));
        held[2][4] = 1'b1;
        cycles(30);
        check("t6_ignored_key", 32'(pulse_cnt - base), 32'd0);
        held[3][3] = 1'b0;
        exp_q.push_back(key_code(2, 4));
        wait_pulse(base + 1, 80, "t6_pulse");
        cycles(5);
        held[2][4] = 1'b0;
        cycles(20);

        // Randomised presses
        for (int n = 0; n < 12; n++) begin
            int r;
            int c;
            r = $urandom_range(ROWS - 1, 0);
            c = $urandom_range(COLS - 1, 0);
            press(r, c);
            cycles($urandom_range(70, 45));
            held[r][c] = 1'b0;
            cycles($urandom_range(30, 16));
        end
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while a key is down
        base = pulse_cnt;
        press(0, 1);
        wait_pulse(base + 1, 80, "ar_pulse");
        cycles(2);
        check("ar_pre_key_down", 32'(key_down), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("ar_col_n", 32'(col_n), 32'h1f);
        check("ar_button", 32'(button), 32'(KEY_NONE));
        check("ar_valid", 32'(valid_press), 32'd0);
        check("ar_key_down", 32'(key_down), 32'd0);
        held[0][1] = 1'b0;
        cycles(2);
        resetn = 1'b1;
        cycles(20);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
